key_reader: RTL and testbench

Conditions the raw active-low DE0-CV push-buttons (KEY[3:0]) into clean, single-clock-domain control signals for the LED logic. Each key is synchronised, debounced by a per-key state machine, and reported as a debounced level, one-cycle press/release pulses, and a press-toggled flag. LED blocks run from `clk` and consume these outputs instead of clocking or clearing directly from a raw KEY line.

---
 rtl/key_reader_if.sv | 26 ++
 rtl/key_reader.sv | 140 ++++++++++++++
 tb/tb_key_reader.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/key_reader_if.sv
// Push-button bundle: raw active-low keys in, debounced level/pulse/toggle out.
interface key_reader_if #(
   parameter int unsigned NKEYS = 4
);
   logic [NKEYS-1:0] key_n;
   logic [NKEYS-1:0] key_level;
   logic [NKEYS-1:0] key_press;
   logic [NKEYS-1:0] key_release;
   logic [NKEYS-1:0] key_toggle;

   modport master (
      output key_n,
      input  key_level,
      input  key_press,
      input  key_release,
      input  key_toggle
   );

   modport slave (
      input  key_n,
      output key_level,
      output key_press,
      output key_release,
      output key_toggle
   );
endinterface

// File: rtl/key_reader.sv
// Synchronises and debounces NKEYS raw active-low buttons into a clean level,
// one-cycle press/release pulses and a press-toggled flag per key.
module key_reader #(
   parameter int unsigned NKEYS           = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
   input  logic         clk,
   input  logic         clr,
   key_reader_if.slave  kif
);

   localparam int unsigned         CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0]       CNT_ONE  = CW'(1);
   localparam logic [CW-1:0]       CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      RELEASED     = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_e;

   logic [NKEYS-1:0] sync1_q;
   logic [NKEYS-1:0] sync2_q;

   logic [NKEYS-1:0] level_vec;
   logic [NKEYS-1:0] press_vec;
   logic [NKEYS-1:0] release_vec;
   logic [NKEYS-1:0] toggle_vec;

   // Inversion happens at the first flop so everything downstream is pressed-high.
   always_ff @(posedge clk) begin
      if (clr) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= ~kif.key_n;
         sync2_q <= sync1_q;
      end
   end

   for (genvar i = 0; i < NKEYS; i++) begin : g_key
      state_e        state_q, state_d;
      logic [CW-1:0] cnt_q, cnt_d;
      logic          level_q, level_d;
      logic          press_q, press_d;
      logic          rel_q, rel_d;
      logic          tog_q, tog_d;
      logic          s;

      assign s = sync2_q[i];

      always_ff @(posedge clk) begin
         if (clr) begin
            state_q <= RELEASED;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            tog_q   <= 1'b0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            tog_q   <= tog_d;
         end
      end

      // A bounce in either WAIT state drops straight back with no partial credit.
      always_comb begin
         state_d = state_q;
         cnt_d   = cnt_q;
         press_d = 1'b0;
         rel_d   = 1'b0;
         tog_d   = tog_q;
         unique case (state_q)
            RELEASED: begin
               if (s) begin
                  state_d = PRESS_WAIT;
                  cnt_d   = CNT_ONE;
               end
            end
            PRESS_WAIT: begin
               if (!s) begin
                  state_d = RELEASED;
                  cnt_d   = '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_d = PRESSED;
                  cnt_d   = '0;
                  press_d = 1'b1;
                  tog_d   = ~tog_q;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            PRESSED: begin
               if (!s) begin
                  state_d = RELEASE_WAIT;
                  cnt_d   = CNT_ONE;
               end
            end
            RELEASE_WAIT: begin
               if (s) begin
                  state_d = PRESSED;
                  cnt_d   = '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_d = RELEASED;
                  cnt_d   = '0;
                  rel_d   = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            default: begin
               state_d = RELEASED;
               cnt_d   = '0;
            end
         endcase
         level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
      end

      assign level_vec[i]   = level_q;
      assign press_vec[i]   = press_q;
      assign release_vec[i] = rel_q;
      assign toggle_vec[i]  = tog_q;

      a_no_dual_pulse : assert property (@(posedge clk) disable iff (clr)
         !(press_q && rel_q));
      a_cnt_bounded : assert property (@(posedge clk) disable iff (clr)
         cnt_q <= CNT_LAST);
   end

   assign kif.key_level   = level_vec;
   assign kif.key_press   = press_vec;
   assign kif.key_release = release_vec;
   assign kif.key_toggle  = toggle_vec;

endmodule

// File: tb/tb_key_reader.sv
// Scoreboarded bench: a run-length debounce model predicts pulses and levels,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_key_reader;

   localparam int unsigned NK = 4;
   localparam int unsigned DB = 8;

   typedef struct {
      int cyc;
      int key;
      bit press;
      bit tog;
   } ev_t;

   logic clk = 1'b0;
   logic clr = 1'b1;
   always #5 clk = ~clk;

   key_reader_if #(.NKEYS(NK)) kif ();

   key_reader #(.NKEYS(NK), .DEBOUNCE_CYCLES(DB)) dut (
      .clk (clk),
      .clr (clr),
      .kif (kif)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   ev_t exp_q[$];
   bit  m_s1[NK];
   bit  m_s2[NK];
   bit  m_lvl[NK];
   bit  m_tog[NK];
   int  m_run[NK];

   // Reference: a level is accepted once the synchronised input has disagreed
   // with the current debounced level for DB consecutive edges.
   always @(posedge clk) begin
      cyc = cyc + 1;
      for (int k = 0; k < NK; k++) begin
         if (clr) begin
            m_s1[k] = 1'b0; m_s2[k] = 1'b0;
            m_lvl[k] = 1'b0; m_tog[k] = 1'b0; m_run[k] = 0;
         end else begin
            if (m_s2[k] != m_lvl[k]) begin
               m_run[k] = m_run[k] + 1;
               if (m_run[k] == DB) begin
                  ev_t e;
                  m_lvl[k] = m_s2[k];
                  m_run[k] = 0;
                  if (m_lvl[k]) m_tog[k] = ~m_tog[k];
                  e.cyc = cyc; e.key = k; e.press = m_lvl[k]; e.tog = m_tog[k];
                  exp_q.push_back(e);
               end
            end else begin
               m_run[k] = 0;
            end
            m_s2[k] = m_s1[k];
            m_s1[k] = ~kif.key_n[k];
         end
      end
   end

   always @(negedge clk) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
         checks++; errors++;
         $display("FAIL missed_pulse key=%0d press=%0d expected_cycle=%0d now=%0d",
                  exp_q[0].key, exp_q[0].press, exp_q[0].cyc, cyc);
         void'(exp_q.pop_front());
      end
      for (int k = 0; k < NK; k++) begin
         checks++;
         if (kif.key_level[k] !== m_lvl[k]) begin
            errors++;
            $display("FAIL level key=%0d cycle=%0d got=%b want=%b", k, cyc, kif.key_level[k], m_lvl[k]);
         end
         checks++;
         if (kif.key_toggle[k] !== m_tog[k]) begin
            errors++;
            $display("FAIL toggle key=%0d cycle=%0d got=%b want=%b", k, cyc, kif.key_toggle[k], m_tog[k]);
         end
         if (kif.key_press[k] === 1'b1 || kif.key_release[k] === 1'b1) begin
            checks++;
            if (kif.key_press[k] && kif.key_release[k]) begin
               errors++;
               $display("FAIL dual_pulse key=%0d cycle=%0d got=both want=one", k, cyc);
            end else if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_pulse key=%0d cycle=%0d got press=%b release=%b want=none",
                        k, cyc, kif.key_press[k], kif.key_release[k]);
            end else begin
               ev_t e;
               e = exp_q.pop_front();
               if (e.cyc != cyc || e.key != k || e.press != kif.key_press[k]) begin
                  errors++;
                  $display("FAIL pulse cycle=%0d got key=%0d press=%b want key=%0d press=%b at cycle %0d",
                           cyc, k, kif.key_press[k], e.key, e.press, e.cyc);
               end
            end
         end
      end
   end

   task automatic hold(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drive(input logic [NK-1:0] kn, input int n);
      kif.key_n = kn;
      hold(n);
   endtask

   initial begin
      logic [NK-1:0] kn;
      kif.key_n = '1;
      clr = 1'b1;
      hold(3);
      checks++;
      if (kif.key_level !== '0 || kif.key_press !== '0 || kif.key_release !== '0 || kif.key_toggle !== '0) begin
         errors++;
         $display("FAIL reset_outputs got=%b%b%b%b want=all zero",
                  kif.key_level, kif.key_press, kif.key_release, kif.key_toggle);
      end
      clr = 1'b0;
      hold(50);

      drive(4'b1110, 40);
      drive(4'b1111, 40);

      drive(4'b1101, 3);
      drive(4'b1111, 2);
      drive(4'b1101, 5);
      drive(4'b1111, 1);
      drive(4'b1101, 30);
      drive(4'b1111, 30);

      drive(4'b1011, 7);
      drive(4'b1111, 30);

      for (int r = 0; r < 3; r++) begin
         drive(4'b0111, 20);
         drive(4'b1111, 20);
      end

      drive(4'b0110, 20);
      drive(4'b1111, 20);

      // Key held while reset lands mid-count; it must re-debounce as a fresh press.
      drive(4'b1110, 7);
      clr = 1'b1;
      hold(3);
      clr = 1'b0;
      hold(30);
      drive(4'b1111, 30);

      kn = '1;
      for (int c = 0; c < 4000; c++) begin
         for (int k = 0; k < NK; k++) begin
            if ($urandom_range(0, 9) == 0) kn[k] = ~kn[k];
         end
         kif.key_n = kn;
         clr = ($urandom_range(0, 499) == 0);
         hold(1 + $urandom_range(0, 3));
      end
      clr = 1'b0;
      drive(4'b1111, 40);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain got=%0d pending want=0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
